// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the 1-to-4 demux: one upstream offer channel, four
// downstream ports and their per-port completed-transfer counters.
interface demux_1_4_stream_if #(
  parameter int DATA_LENGTH = 8,
  parameter int CNT_WIDTH   = 8
);
  logic [DATA_LENGTH-1:0]   in_data;
  logic [1:0]               in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [4*DATA_LENGTH-1:0] out_data;
  logic [3:0]               out_valid;
  logic [3:0]               out_ready;
  logic [4*CNT_WIDTH-1:0]   xfer_cnt;

  // The master side is the source/sink environment; the slave side is the demux.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, xfer_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, xfer_cnt
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream demultiplexer: each port owns a one-entry holding slot and a
// wrapping counter of completed output handshakes.
module demux_1_4_stream #(
  parameter int DATA_LENGTH = 8,
  parameter int CNT_WIDTH   = 8
) (
  input logic              clk,
  input logic              rst,
  demux_1_4_stream_if.slave bus
);

  logic [3:0]             slot_valid;
  logic [DATA_LENGTH-1:0] slot_data [4];
  logic [CNT_WIDTH-1:0]   slot_cnt  [4];

  logic                   in_ready_c;
  logic [3:0]             accept_vec;
  logic [3:0]             handshake_vec;
  logic [4*DATA_LENGTH-1:0] out_data_c;
  logic [4*CNT_WIDTH-1:0]   xfer_cnt_c;

  // Ready only looks at the addressed slot, so a stalled port never blocks the others.
  always_comb begin
    in_ready_c    = 1'b0;
    accept_vec    = 4'b0000;
    handshake_vec = slot_valid & bus.out_ready;
    if (!rst) begin
      in_ready_c = ~slot_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
    end
    if (bus.in_valid && in_ready_c) begin
      accept_vec[bus.in_sel] = 1'b1;
    end
  end

  // An accept on a draining slot overwrites it in place, keeping full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        slot_data[k] <= '0;
        slot_cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept_vec[k]) begin
          slot_data[k]  <= bus.in_data;
          slot_valid[k] <= 1'b1;
        end else if (handshake_vec[k]) begin
          slot_valid[k] <= 1'b0;
        end
        if (handshake_vec[k]) begin
          slot_cnt[k] <= slot_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_data_c = '0;
    xfer_cnt_c = '0;
    for (int k = 0; k < 4; k++) begin
      out_data_c[k*DATA_LENGTH +: DATA_LENGTH] = slot_data[k];
      xfer_cnt_c[k*CNT_WIDTH +: CNT_WIDTH]     = slot_cnt[k];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = slot_valid;
  assign bus.out_data  = out_data_c;
  assign bus.xfer_cnt  = xfer_cnt_c;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed bench for demux_1_4_stream: a table of per-cycle vectors with
// hand-computed expectations, then a counter-wrap streaming sequence.
module tb_demux_1_4_stream;

  localparam int DL = 8;
  localparam int CW = 8;

  typedef struct packed {
    logic        rst;
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [31:0] e_od;
    logic [31:0] e_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  vec_t vecs [18];

  demux_1_4_stream_if #(.DATA_LENGTH(DL), .CNT_WIDTH(CW)) bus ();

  demux_1_4_stream #(.DATA_LENGTH(DL), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input int step,
                            input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                               input logic [7:0] d, input logic [3:0] o);
    rst           = r;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = o;
  endtask

  task automatic checkOutput(input int step, input vec_t v);
    checkField("out_valid", step, {28'd0, bus.out_valid}, {28'd0, v.e_ov});
    checkField("out_data",  step, bus.out_data, v.e_od);
    checkField("xfer_cnt",  step, bus.xfer_cnt, v.e_cnt);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //           rst   vld   sel    data   ordy    rdy   ov     od            cnt
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 4'hF, 1'b0, 4'h0, 32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b1, 2'd1, 8'hFF, 4'hF, 1'b0, 4'h0, 32'h00000000, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'h1, 32'h00000011, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'h2, 32'h00002211, 32'h00000001};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 4'h4, 32'h00332211, 32'h00000101};
    vecs[5]  = '{1'b0, 1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 4'h8, 32'h44332211, 32'h00010101};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'hEE, 4'hF, 1'b1, 4'h0, 32'h44332211, 32'h01010101};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'hB, 1'b1, 4'h4, 32'h44A52211, 32'h01010101};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 8'h5A, 4'hB, 1'b0, 4'h4, 32'h44A52211, 32'h01010101};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 8'h5A, 4'hF, 1'b1, 4'h4, 32'h445A2211, 32'h01020101};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 8'h5A, 4'hF, 1'b1, 4'h0, 32'h445A2211, 32'h01030101};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 8'h66, 4'hD, 1'b1, 4'h2, 32'h445A6611, 32'h01030101};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 8'h67, 4'hD, 1'b0, 4'h2, 32'h445A6611, 32'h01030101};
    vecs[13] = '{1'b0, 1'b1, 2'd3, 8'h77, 4'h5, 1'b1, 4'hA, 32'h775A6611, 32'h01030101};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 8'h88, 4'h0, 1'b1, 4'hB, 32'h775A6688, 32'h01030101};
    vecs[15] = '{1'b1, 1'b1, 2'd2, 8'h99, 4'hF, 1'b0, 4'h0, 32'h00000000, 32'h00000000};
    vecs[16] = '{1'b0, 1'b1, 2'd0, 8'h12, 4'h0, 1'b1, 4'h1, 32'h00000012, 32'h00000000};
    vecs[17] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h1, 1'b1, 4'h0, 32'h00000012, 32'h00000001};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      #1;
      checkField("in_ready", i, {31'd0, bus.in_ready}, {31'd0, vecs[i].e_rdy});
      @(posedge clk);
      #1;
      checkOutput(i, vecs[i]);
    end

    // Counter wrap on port 0: 256 back-to-back words, in order, then one more.
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 4'hF);
    @(posedge clk);
    #1;
    checkField("wrap_reset_cnt", 100, bus.xfer_cnt, 32'h0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 8'(i), 4'hF);
      #1;
      checkField("wrap_in_ready", 200 + i, {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      checkField("wrap_valid", 200 + i, {31'd0, bus.out_valid[0]}, 32'd1);
      checkField("wrap_data",  200 + i, {24'd0, bus.out_data[7:0]}, 32'(i[7:0]));
      checkField("wrap_cnt",   200 + i, {24'd0, bus.xfer_cnt[7:0]}, 32'(i[7:0]));
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    @(posedge clk);
    #1;
    checkField("wrap_cnt_zero", 500, bus.xfer_cnt, 32'h00000000);
    checkField("wrap_drained",  500, {28'd0, bus.out_valid}, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'hC3, 4'hF);
    @(posedge clk);
    #1;
    checkField("wrap_257_data", 501, {24'd0, bus.out_data[7:0]}, 32'h000000C3);
    checkField("wrap_257_pend", 501, bus.xfer_cnt, 32'h00000000);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    @(posedge clk);
    #1;
    checkField("wrap_cnt_one",  502, bus.xfer_cnt, 32'h00000001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
